apb_master_ctrl: RTL and testbench

APB master sequencer for the AHB2APB bridge. Accepts one transfer request at a time over a valid/ready request port and decodes the address to one of three APB slaves. It drives the APB SETUP and ACCESS phases (Pselx, Penable, Pwrite, Paddr, Pwdata) into the APB interface stage, waits on Pready with a bounded timeout, and returns read data and error status on a single-cycle response strobe.

---
 rtl/apb_master_ctrl.sv | 147 ++++++++++++++
 tb/tb_apb_master_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB master sequencer with 3-slave address decode, bounded Pready wait
// and a single-cycle response strobe. Rev 1.0
`default_nettype none

module apb_master_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata,
  input  logic        Pready,
  input  logic        Pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_t;

  localparam logic [7:0] c_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_pselx;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic        r_busy;

  logic [2:0]  w_sel;
  logic        w_timeout_hit;
  logic        w_done;
  logic        w_accept;

  // Each slave owns a 64 MB window starting at 0x8000_0000.
  always_comb begin
    w_sel = 3'b000;
    case (req_addr[31:26])
      6'b100000: w_sel = 3'b001;
      6'b100001: w_sel = 3'b010;
      6'b100010: w_sel = 3'b100;
      default:   w_sel = 3'b000;
    endcase
  end

  assign w_timeout_hit = (r_state == ACCESS) && !Pready && (r_cnt == c_LAST_WAIT);
  assign w_done        = (r_state == ACCESS) && (Pready || w_timeout_hit);
  assign req_ready     = !Hreset && ((r_state == IDLE) || w_done);
  assign w_accept      = req_valid && req_ready;

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_pselx     <= 3'b000;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= 32'd0;
      r_pwdata    <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      case (r_state)
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_timeout_hit ? 1'b1 : Pslverr;
            r_rsp_rdata <= (Pready && !r_pwrite && !Pslverr) ? Prdata : 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DERR: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_state     <= IDLE;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase

      // Leaving ACCESS and idling share the accept path so back-to-back needs no bubble.
      if ((r_state == IDLE) || w_done) begin
        r_penable <= 1'b0;
        if (w_accept && (w_sel != 3'b000)) begin
          r_pselx  <= w_sel;
          r_pwrite <= req_write;
          r_paddr  <= req_addr;
          r_pwdata <= req_wdata;
          r_cnt    <= 8'd0;
          r_state  <= SETUP;
          r_busy   <= 1'b1;
        end else if (w_accept) begin
          r_pselx <= 3'b000;
          r_state <= DERR;
          r_busy  <= 1'b1;
        end else begin
          r_pselx <= 3'b000;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign Pselx     = r_pselx;
  assign Penable   = r_penable;
  assign Pwrite    = r_pwrite;
  assign Paddr     = r_paddr;
  assign Pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed and randomized transfers checked against a transaction-level
// model of the APB master (decode windows, latency and response rules).
`default_nettype none

module tb_apb_master_ctrl;

  localparam int T = 4;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_ctrl #(.TIMEOUT(T)) dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 Hclk = ~Hclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: three consecutive 64 MB windows above 0x8000_0000.
  function automatic logic [2:0] model_sel(input logic [31:0] a);
    longint unsigned off;
    if (a < 32'h8000_0000) return 3'b000;
    off = longint'(a) - 64'h8000_0000;
    if (off >= 3 * 64'h0400_0000) return 3'b000;
    return 3'(1 << (off / 64'h0400_0000));
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pselx"}, 32'(Pselx), 32'd0);
    chk({tag, "_penable"}, 32'(Penable), 32'd0);
    chk({tag, "_pwrite"}, 32'(Pwrite), 32'd0);
    chk({tag, "_paddr"}, Paddr, 32'd0);
    chk({tag, "_pwdata"}, Pwdata, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One complete transfer: nwait Pready-low ACCESS cycles before Pready (nwait >= T times out).
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int nwait, input logic [31:0] rd, input logic serr);
    logic [2:0]  sel;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        last;
    sel = model_sel(addr);
    if (nwait >= T) begin
      exp_err = 1'b1;
      exp_rd  = 32'd0;
    end else begin
      exp_err = serr;
      exp_rd  = (!wr && !serr) ? rd : 32'd0;
    end

    @(posedge Hclk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge Hclk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    chk("no_stray_rsp", 32'(rsp_valid), 32'd0);
    @(posedge Hclk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
    Pready = 1'($urandom); Pslverr = 1'($urandom); Prdata = $urandom;
    @(negedge Hclk);
    chk("k1_busy", 32'(busy), 32'd1);
    chk("k1_pselx", 32'(Pselx), 32'(sel));
    chk("k1_penable", 32'(Penable), 32'd0);
    chk("k1_ready", 32'(req_ready), 32'd0);

    if (sel == 3'b000) begin
      @(posedge Hclk); #1;
      @(negedge Hclk);
      chk("derr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("derr_rsp_err", 32'(rsp_err), 32'd1);
      chk("derr_rsp_rdata", rsp_rdata, 32'd0);
      chk("derr_pselx", 32'(Pselx), 32'd0);
      chk("derr_penable", 32'(Penable), 32'd0);
    end else begin
      chk("setup_paddr", Paddr, addr);
      chk("setup_pwrite", 32'(Pwrite), 32'(wr));
      chk("setup_pwdata", Pwdata, wd);
      for (int cyc = 0; cyc < T; cyc++) begin
        @(posedge Hclk); #1;
        Pready = (cyc == nwait); Pslverr = serr; Prdata = rd;
        last = (cyc == nwait) || (cyc == T - 1);
        @(negedge Hclk);
        chk("acc_penable", 32'(Penable), 32'd1);
        chk("acc_pselx", 32'(Pselx), 32'(sel));
        chk("acc_paddr", Paddr, addr);
        chk("acc_pwrite", 32'(Pwrite), 32'(wr));
        chk("acc_pwdata", Pwdata, wd);
        chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("acc_ready", 32'(req_ready), 32'(last));
        if (last) break;
      end
      @(posedge Hclk); #1;
      Pready = 1'($urandom); Pslverr = 1'($urandom); Prdata = $urandom;
      @(negedge Hclk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("end_pselx", 32'(Pselx), 32'd0);
      chk("end_penable", 32'(Penable), 32'd0);
      chk("end_paddr_hold", Paddr, addr);
    end
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    Hreset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    Prdata = 32'd0; Pready = 1'b0; Pslverr = 1'b0;
    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    chk_idle_outputs("reset");
    chk("reset_ready", 32'(req_ready), 32'd0);
    @(posedge Hclk); #1;
    Hreset = 1'b0;

    // Directed cases
    run_txn(32'h8000_0010, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0);
    run_txn(32'h8400_0004, 1'b1, 32'h8765_4321, 3, 32'hDEAD_BEEF, 1'b0);
    run_txn(32'hC000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    run_txn(32'h8BFF_FFFC, 1'b0, 32'h0, T + 2, 32'h5555_AAAA, 1'b0);
    run_txn(32'h87FF_FFFF, 1'b0, 32'h0, 1, 32'h0F0F_0F0F, 1'b1);
    run_txn(32'h8C00_0000, 1'b1, 32'h1, 0, 32'h0, 1'b0);
    run_txn(32'h7FFF_FFFF, 1'b1, 32'h2, 0, 32'h0, 1'b0);

    // Back-to-back reads: 0x8000_0000 then 0x8800_0000
    @(posedge Hclk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0000;
    @(posedge Hclk); #1;
    req_valid = 1'b0;
    @(negedge Hclk);
    chk("b2b_k1_pselx", 32'(Pselx), 32'd1);
    @(posedge Hclk); #1;
    Pready = 1'b1; Pslverr = 1'b0; Prdata = 32'hAAAA_0001;
    req_valid = 1'b1; req_addr = 32'h8800_0000;
    @(negedge Hclk);
    chk("b2b_k2_penable", 32'(Penable), 32'd1);
    chk("b2b_k2_ready", 32'(req_ready), 32'd1);
    @(posedge Hclk); #1;
    req_valid = 1'b0; Pready = 1'b0; Prdata = 32'hBBBB_0002;
    @(negedge Hclk);
    chk("b2b_k3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_k3_rsp_rdata", rsp_rdata, 32'hAAAA_0001);
    chk("b2b_k3_pselx", 32'(Pselx), 32'd4);
    chk("b2b_k3_penable", 32'(Penable), 32'd0);
    chk("b2b_k3_paddr", Paddr, 32'h8800_0000);
    @(posedge Hclk); #1;
    Pready = 1'b1;
    @(negedge Hclk);
    chk("b2b_k4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_k4_penable", 32'(Penable), 32'd1);
    @(posedge Hclk); #1;
    Pready = 1'b0;
    @(negedge Hclk);
    chk("b2b_k5_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_k5_rsp_rdata", rsp_rdata, 32'hBBBB_0002);
    chk("b2b_k5_rsp_err", 32'(rsp_err), 32'd0);
    chk("b2b_k5_pselx", 32'(Pselx), 32'd0);

    // Reset during ACCESS drops the transfer
    @(posedge Hclk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8400_0100; req_wdata = 32'hCAFE_F00D;
    @(posedge Hclk); #1;
    req_valid = 1'b0;
    @(posedge Hclk); #1;
    Pready = 1'b0;
    @(negedge Hclk);
    chk("rst_acc_penable", 32'(Penable), 32'd1);
    @(posedge Hclk); #1;
    Hreset = 1'b1;
    @(negedge Hclk);
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(negedge Hclk);
    chk_idle_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(posedge Hclk); #1;
      @(negedge Hclk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_txn(32'h8000_0020, 1'b0, 32'h0, 0, 32'h0BAD_CAFE, 1'b0);

    // Randomized transfers: mostly legal windows, some decode errors and timeouts
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0:       a = $urandom;
        default: a = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
      endcase
      run_txn(a, 1'($urandom), $urandom, int'($urandom_range(0, T + 1)), $urandom,
              ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
